frame_arbiter: RTL
==================

# frame_arbiter

Two-input frame-interface arbiter that shares one downstream frame consumer between two frame sources. Typical sources are two fifo2frame-style converters, for example the raw IR path and a filtered path. Ownership of the output is granted for one whole frame at a time, from an accepted start-of-frame to an accepted end-of-frame, so frames are never interleaved. The block sits between the stream-to-frame converters and the filter/output chain, and reports per-source frame counts and dropped-beat counts to the register bank.

## Interface
Parameters:
- DATA_WIDTH, 24, pixel data width.

Ports:
- clk  in  1  system clock. One clock domain.
- rst  in  1  reset, synchronous and active-high.
- cfg_en  in  2  per-source enable; bit n enables source n.
- cfg_prio  in  1  0 = round-robin, 1 = fixed priority (source 0 wins).
- inN_frm_val  in  1  source N beat valid (N = 0, 1).
- inN_frm_rdy  out  1  arbiter ready to source N.
- inN_frm_data  in  DATA_WIDTH  source N pixel.
- inN_frm_sof / inN_frm_eof / inN_frm_sol / inN_frm_eol  in  1 each  source N framing flags.
- out_frm_val  out  1  output beat valid.
- out_frm_rdy  in  1  downstream ready.
- out_frm_data  out  DATA_WIDTH  output pixel.
- out_frm_sof / out_frm_eof / out_frm_sol / out_frm_eol  out  1 each  output framing flags.
- grant  out  2  one-hot current owner; 2'b00 when idle.
- busy  out  1  high while a frame is in progress.
- frm_cnt0 / frm_cnt1  out  16 each  completed frames per source; wraps.
- drop_cnt  out  16  discarded out-of-frame beats, both sources combined; saturates at 16'hFFFF.

## Operation
A beat is accepted on a handshake: val & rdy. States are IDLE, GNT0 and GNT1.

Requests:
- reqN = cfg_en[N] & inN_frm_val & inN_frm_sof.

IDLE:
- Outputs: out_frm_val = 0, all out flags = 0, out data = 0.
- inN_frm_rdy = 0 when reqN is high.
- Flushing: inN_frm_rdy = 1 when inN_frm_val & ~inN_frm_sof, or when source N is disabled. Each beat flushed this way is discarded and increments drop_cnt.
- Arbitration when only one reqN is high: go to GNTn.
- Arbitration when both are high:
  - cfg_prio = 1: go to GNT0.
  - cfg_prio = 0: grant the source not recorded in last_grant.
- last_grant reset value is 1, so source 0 wins the first tie.

GNTn:
- Combinational pass-through: out_frm_* = inN_frm_*, and inN_frm_rdy = out_frm_rdy.
- The other source has rdy = 0; its beats are held upstream and are not dropped.
- On an accepted beat with eof:
  - go to IDLE;
  - increment frm_cntN;
  - set last_grant = N.
- A beat carrying both sof and eof (a 1x1 frame) completes the grant in a single beat.
- cfg_en and cfg_prio changes do not affect a frame in progress. A disabled owner still finishes its frame.
- A sof seen mid-frame from the owner is passed through unchanged; it is not checked.

Drop counting:
- If both sources flush in the same cycle, drop_cnt increments by 2, saturating.

## Timing
- Reset (rst high at a clk edge):
  - state = IDLE, last_grant = 1;
  - all counters = 0, grant = 0, busy = 0;
  - out_frm_val = 0, out flags = 0, out data = 0;
  - inN_frm_rdy = 0 while rst is high.
- Reset during a frame truncates it with no eof to downstream. This is intended; a software reset clears the whole chain.
- Grant latency: a request in IDLE at edge k puts the state in GNTn after edge k. The sof beat appears on out_frm_* in cycle k+1, zero-latency from the source.
- Sources must hold val/data/flags stable until accepted, as normal frame-interface rules require.
- Frame gap: the eof accept moves the state to IDLE, giving at least one idle cycle before the next grant.
- Data path latency inside a grant is 0 cycles. Throughput is 1 beat/cycle.
- grant and busy are registered, decoded from state, and valid from the cycle after the edge that changed state.
- Counter width: 16-bit; frm_cntN wraps from FFFF to 0000.

## Test plan
- Single source: source 0 sends a 4x2 frame (8 beats) with out_frm_rdy = 1 -> out beats 1..8 match with correct sof/eol/eof; frm_cnt0 = 1; grant = 01 during the frame and 00 after; 1-cycle gap.
- Round-robin tie: both sources hold sof for 3 frames each, cfg_prio = 0 -> grant order 0,1,0,1,0,1; frm_cnt0 = frm_cnt1 = 3; no beats dropped.
- Fixed priority: same stimulus with cfg_prio = 1 -> all 3 source-0 frames first, then source 1; drop_cnt = 0.
- Backpressure and interleave guard: random out_frm_rdy toggling while source 1 requests mid-frame of source 0 -> no source-1 beat appears before the source-0 eof; data is bit-exact.
- Drop and disable: source 1 presents 5 non-sof beats while idle -> drop_cnt = 5. cfg_en = 2'b10 with source 0 requesting -> source 0 is flushed, with no grant to it.
- Edge cases:
  - 1x1 frame (sof & eof in one beat) -> frm_cnt increments and the state returns to IDLE.
  - rst asserted mid-frame -> all outputs and counters 0 next cycle.
  - frm_cnt0 preloaded near wrap by running 65536 frames -> reads 0.

Source files
------------

// File: rtl/frame_arbiter_if.sv
// frame_arbiter_if: one frame-interface link (valid/ready beat with pixel data
// and sof/eof/sol/eol framing flags).
//   master : drives val, data, sof, eof, sol, eol; receives rdy
//   slave  : receives val, data, sof, eof, sol, eol; drives rdy
interface frame_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 24
);
  logic                  val;
  logic                  rdy;
  logic [DATA_WIDTH-1:0] data;
  logic                  sof;
  logic                  eof;
  logic                  sol;
  logic                  eol;

  modport master (output val, data, sof, eof, sol, eol, input rdy);
  modport slave  (input val, data, sof, eof, sol, eol, output rdy);
endinterface

// File: rtl/frame_arbiter.sv
// frame_arbiter: shares one downstream frame consumer between two frame
// sources. Ownership is granted per whole frame (accepted sof .. accepted eof),
// so frames are never interleaved. Out-of-frame beats arriving while idle are
// flushed and counted.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   cfg_en[1:0]       per-source enable (disabled sources are flushed when idle)
//   cfg_prio          0 = round-robin, 1 = fixed priority (source 0 wins)
//   in0, in1          source frame links (slave side)
//   out               downstream frame link (master side)
//   grant[1:0]        one-hot current owner, registered; 00 when idle
//   busy              registered, high while a frame is in progress
//   frm_cnt0/1        completed frames per source, wrapping
//   drop_cnt          flushed beats from both sources, saturating
module frame_arbiter #(
  parameter int unsigned DATA_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           cfg_en,
  input  logic                 cfg_prio,
  frame_arbiter_if.slave       in0,
  frame_arbiter_if.slave       in1,
  frame_arbiter_if.master      out,
  output logic [1:0]           grant,
  output logic                 busy,
  output logic [15:0]          frm_cnt0,
  output logic [15:0]          frm_cnt1,
  output logic [15:0]          drop_cnt
);

  localparam int unsigned CNT_W = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GNT0 = 2'd1;
  localparam logic [1:0] ST_GNT1 = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             last_grant;
  logic             req0;
  logic             req1;
  logic             flush0;
  logic             flush1;
  logic             done0;
  logic             done1;
  logic [CNT_W:0]   drop_sum;
  logic [CNT_W-1:0] drop_nxt;

  assign req0 = cfg_en[0] & in0.val & in0.sof;
  assign req1 = cfg_en[1] & in1.val & in1.sof;

  // Next state, handshake steering and pass-through mux
  always_comb begin
    state_nxt = state;
    out.val   = 1'b0;
    out.data  = DATA_WIDTH'(0);
    out.sof   = 1'b0;
    out.eof   = 1'b0;
    out.sol   = 1'b0;
    out.eol   = 1'b0;
    in0.rdy   = 1'b0;
    in1.rdy   = 1'b0;
    flush0    = 1'b0;
    flush1    = 1'b0;
    done0     = 1'b0;
    done1     = 1'b0;

    case (state)
      ST_IDLE: begin
        // A disabled source or a beat without sof cannot start a frame: drain it
        in0.rdy = ~cfg_en[0] | (in0.val & ~in0.sof);
        in1.rdy = ~cfg_en[1] | (in1.val & ~in1.sof);
        flush0  = in0.val & in0.rdy;
        flush1  = in1.val & in1.rdy;
        if (req0 && req1) begin
          // Round-robin picks the source that did not own the previous frame
          state_nxt = (cfg_prio || last_grant) ? ST_GNT0 : ST_GNT1;
        end else if (req0) begin
          state_nxt = ST_GNT0;
        end else if (req1) begin
          state_nxt = ST_GNT1;
        end
      end

      ST_GNT0: begin
        out.val  = in0.val;
        out.data = in0.data;
        out.sof  = in0.sof;
        out.eof  = in0.eof;
        out.sol  = in0.sol;
        out.eol  = in0.eol;
        in0.rdy  = out.rdy;
        done0    = in0.val & out.rdy & in0.eof;
        if (done0) begin
          state_nxt = ST_IDLE;
        end
      end

      ST_GNT1: begin
        out.val  = in1.val;
        out.data = in1.data;
        out.sof  = in1.sof;
        out.eof  = in1.eof;
        out.sol  = in1.sol;
        out.eol  = in1.eol;
        in1.rdy  = out.rdy;
        done1    = in1.val & out.rdy & in1.eof;
        if (done1) begin
          state_nxt = ST_IDLE;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // Nothing is accepted or offered while reset is held
    if (rst) begin
      in0.rdy = 1'b0;
      in1.rdy = 1'b0;
      out.val = 1'b0;
    end
  end

  // State register; grant/busy are decoded from the next state so they line
  // up with the state they describe
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      grant      <= 2'b00;
      busy       <= 1'b0;
    end else begin
      state <= state_nxt;
      grant <= {state_nxt == ST_GNT1, state_nxt == ST_GNT0};
      busy  <= (state_nxt != ST_IDLE);
      if (done0) begin
        last_grant <= 1'b0;
      end else if (done1) begin
        last_grant <= 1'b1;
      end
    end
  end

  // Up to two flushed beats per cycle, clamped at all-ones
  assign drop_sum = {1'b0, drop_cnt} + (CNT_W+1)'(flush0) + (CNT_W+1)'(flush1);
  assign drop_nxt = drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];

  // Statistics counters
  always_ff @(posedge clk) begin
    if (rst) begin
      frm_cnt0 <= '0;
      frm_cnt1 <= '0;
      drop_cnt <= '0;
    end else begin
      if (done0) begin
        frm_cnt0 <= frm_cnt0 + CNT_W'(1);
      end
      if (done1) begin
        frm_cnt1 <= frm_cnt1 + CNT_W'(1);
      end
      drop_cnt <= drop_nxt;
    end
  end

endmodule
